utopia_tx_scheduler: RTL and testbench
======================================

Name: utopia_tx_scheduler

Overview:
- Round-robin transmit scheduler for a shared UTOPIA Level-2 style transmit bus.
- Up to NumTx cell sources (per-port cell FIFOs, first-word-fall-through) request the bus.
- The block polls the target PHY's cell-available flag (clav) by address, grants one source, and streams one CellBytes-byte cell with soc/en framing.
- Sits between the per-port transmit FIFOs and the Utopia interface data/soc/en/clav signals.

Parameters:
- IfWidth, 8, cell byte/word width on the data bus.
- NumTx, 4, number of requesters/PHY ports (1..31).
- AddrWidth, 5, PHY address width; all-ones is the null address.
- CellBytes, 53, words per cell.

Ports:
- clk_in  input  1  bus clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NumTx  per-source "full cell available" flag.
- cell_data_in  input  IfWidth  data of the granted source; valid in any cycle rd_en=1.
- grant  output  NumTx  one-hot grant, registered.
- rd_en  output  1  pop strobe to the granted source FIFO.
- cell_done  output  1  one-cycle pulse after the last word.
- phy_addr  output  AddrWidth  polled/selected PHY address.
- clav  input  1  PHY cell-available flag for phy_addr.
- data  output  IfWidth  transmit bus data, registered.
- soc  output  1  start of cell, high on word 0 only.
- en_n  output  1  transmit enable, active-low.
- busy  output  1  high when state is not IDLE.
- cells_sent  output  16  count of completed cells; wraps 0xFFFF->0.

Behaviour:
- Reset values (asynchronous on reset=1, applied immediately even mid-cell; the partial cell is abandoned):
  - state=IDLE, grant=0, rd_en=0, cell_done=0.
  - phy_addr=all-ones, data=0, soc=0, en_n=1, busy=0, cells_sent=0.
  - rr_ptr=0, cand=0.
- FSM states: IDLE, POLL, CHECK, SEND, GAP.
- IDLE:
  - If req!=0: cand = first set bit of req searching from rr_ptr upward, wrapping at NumTx-1->0.
  - phy_addr<=cand; go to POLL.
  - Otherwise hold, with phy_addr=all-ones.
- POLL: one cycle with phy_addr stable; go to CHECK.
- CHECK: sample clav.
  - If clav=1 and req[cand]=1: grant[cand]<=1, word counter<=0, go to SEND.
  - Else: rr_ptr<=cand+1 (mod NumTx), phy_addr<=all-ones, go to IDLE. A not-ready PHY is skipped for one round.
- SEND, exactly CellBytes cycles:
  - rd_en=1 (combinational from state).
  - data<=cell_data_in, en_n<=0, soc<=(counter==0); registered, so bus lags rd_en by one cycle.
  - On counter==CellBytes-1: rr_ptr<=cand+1 (mod NumTx), go to GAP.
  - req and clav changes during SEND are ignored; a started cell always completes.
- GAP, one cycle:
  - Last word is on the bus; cell_done=1; cells_sent++.
  - Next cycle: grant<=0, en_n<=1, soc<=0, phy_addr<=all-ones, go to IDLE.
  - data holds its last value.
- Timing from req seen in IDLE at cycle T with clav=1:
  - POLL T+1, CHECK T+2, SEND T+3..T+55, GAP T+56, IDLE T+57.
  - grant high T+3..T+56.
  - soc high at T+4 only; en_n low T+4..T+56.
  - cell_done at T+56.
  - Minimum cell-to-cell interval is 57 cycles.
- Fairness: the source just served or skipped gets lowest priority next; each of N continuously requesting sources is served once per N cells.
- Invariants: grant is one-hot or zero; rd_en=1 implies exactly one grant bit set; soc=1 implies en_n=0.

Test Plan:
- Reset then req=0001, clav=1 at T -> phy_addr=0 at T+1, grant=0001 T+3..T+56, 53 rd_en pulses, soc only at T+4, bytes 0x00..0x34 on data T+4..T+56, cell_done at T+56, cells_sent=1.
- req=1111 held, clav=1 -> grants in order 0001,0010,0100,1000,0001; each cell 57 cycles; cells_sent=5 after 285 cycles.
- req=0011, clav=0 while phy_addr=0, else 1 -> source 0 polled and skipped (no grant, no rd_en), source 1 sent next, then source 0 polled again.
- During SEND at word 20, drop req and clav -> cell still completes 53 words; cell_done pulses once.
- Assert reset at word 30 of a cell -> same cycle en_n=1, soc=0, grant=0, rd_en=0, phy_addr=all-ones; after release with req=0001 a fresh cell starts with soc.
- Preload cells_sent=0xFFFF via 65535 cells (or a force), send one more cell -> cells_sent=0x0000.

Source files
------------

// File: rtl/utopia_tx_scheduler.sv
// Round-robin transmit scheduler for a shared UTOPIA Level-2 style bus.
// Polls the candidate PHY's clav, grants one source and streams a full cell with soc/en_n framing.
module utopia_tx_scheduler #(
    parameter int IfWidth   = 8,
    parameter int NumTx     = 4,
    parameter int AddrWidth = 5,
    parameter int CellBytes = 53
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [NumTx-1:0]     req,
    input  logic [IfWidth-1:0]   cell_data_in,
    output logic [NumTx-1:0]     grant,
    output logic                 rd_en,
    output logic                 cell_done,
    output logic [AddrWidth-1:0] phy_addr,
    input  logic                 clav,
    output logic [IfWidth-1:0]   data,
    output logic                 soc,
    output logic                 en_n,
    output logic                 busy,
    output logic [15:0]          cells_sent
);

    localparam int PtrW = (NumTx > 1) ? $clog2(NumTx) : 1;
    localparam int CntW = (CellBytes > 1) ? $clog2(CellBytes) : 1;
    localparam logic [AddrWidth-1:0] NullAddr = {AddrWidth{1'b1}};
    localparam logic [PtrW-1:0]      LastPtr  = PtrW'(NumTx - 1);
    localparam logic [CntW-1:0]      LastWord = CntW'(CellBytes - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POLL  = 3'd1,
        CHECK = 3'd2,
        SEND  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NumTx-1:0]     grant_q, grant_d;
    logic [PtrW-1:0]      cand_q, cand_d;
    logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AddrWidth-1:0] phy_addr_q, phy_addr_d;
    logic [IfWidth-1:0]   data_q, data_d;
    logic                 soc_q, soc_d;
    logic                 en_n_q, en_n_d;
    logic                 cell_done_q, cell_done_d;
    logic [15:0]          cells_sent_q, cells_sent_d;

    logic [PtrW-1:0]      pick_s;
    logic [PtrW-1:0]      scan_s;
    logic                 pick_found_s;
    logic [NumTx-1:0]     grant_onehot_s;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    assign grant_onehot_s = NumTx'(1'b1) << cand_q;

    // First requesting source at or after rr_ptr, wrapping at the last port.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = rr_ptr_q;
        scan_s       = rr_ptr_q;
        for (int i = 0; i < NumTx; i++) begin
            if (!pick_found_s && req[scan_s]) begin
                pick_found_s = 1'b1;
                pick_s       = scan_s;
            end else begin
                pick_found_s = pick_found_s;
            end
            scan_s = next_ptr(scan_s);
        end
    end

    // Next-state and registered-output logic for the poll/grant/send sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cand_d       = cand_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        phy_addr_d   = phy_addr_q;
        data_d       = data_q;
        soc_d        = soc_q;
        en_n_d       = en_n_q;
        cell_done_d  = 1'b0;
        cells_sent_d = cells_sent_q;
        case (state_q)
            IDLE: begin
                if (req != {NumTx{1'b0}}) begin
                    cand_d     = pick_s;
                    phy_addr_d = AddrWidth'(pick_s);
                    state_d    = POLL;
                end else begin
                    phy_addr_d = NullAddr;
                end
            end
            POLL: begin
                state_d = CHECK;
            end
            CHECK: begin
                // A PHY without room is skipped so it drops to lowest priority.
                if (clav && req[cand_q]) begin
                    grant_d = grant_onehot_s;
                    cnt_d   = {CntW{1'b0}};
                    state_d = SEND;
                end else begin
                    rr_ptr_d   = next_ptr(cand_q);
                    phy_addr_d = NullAddr;
                    state_d    = IDLE;
                end
            end
            SEND: begin
                data_d = cell_data_in;
                en_n_d = 1'b0;
                soc_d  = (cnt_q == {CntW{1'b0}});
                if (cnt_q == LastWord) begin
                    rr_ptr_d     = next_ptr(cand_q);
                    cell_done_d  = 1'b1;
                    cells_sent_d = cells_sent_q + 16'd1;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            GAP: begin
                grant_d    = {NumTx{1'b0}};
                en_n_d     = 1'b1;
                soc_d      = 1'b0;
                phy_addr_d = NullAddr;
                state_d    = IDLE;
            end
            default: begin
                grant_d    = {NumTx{1'b0}};
                en_n_d     = 1'b1;
                soc_d      = 1'b0;
                phy_addr_d = NullAddr;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any partial cell.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= {NumTx{1'b0}};
            cand_q       <= {PtrW{1'b0}};
            rr_ptr_q     <= {PtrW{1'b0}};
            cnt_q        <= {CntW{1'b0}};
            phy_addr_q   <= NullAddr;
            data_q       <= {IfWidth{1'b0}};
            soc_q        <= 1'b0;
            en_n_q       <= 1'b1;
            cell_done_q  <= 1'b0;
            cells_sent_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cand_q       <= cand_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            phy_addr_q   <= phy_addr_d;
            data_q       <= data_d;
            soc_q        <= soc_d;
            en_n_q       <= en_n_d;
            cell_done_q  <= cell_done_d;
            cells_sent_q <= cells_sent_d;
        end
    end

    assign grant      = grant_q;
    assign rd_en      = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign cell_done  = cell_done_q;
    assign phy_addr   = phy_addr_q;
    assign data       = data_q;
    assign soc        = soc_q;
    assign en_n       = en_n_q;
    assign cells_sent = cells_sent_q;

endmodule

// File: tb/tb_utopia_tx_scheduler.sv
// Bench for utopia_tx_scheduler: directed scenarios plus random traffic, checked every cycle
// against a transaction-timeline model (cycle offsets from the moment a request is seen).
module tb_utopia_tx_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 5;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [W-1:0]  cell_data_in;
    logic          clav;
    logic [N-1:0]  grant;
    logic          rd_en;
    logic          cell_done;
    logic [AW-1:0] phy_addr;
    logic [W-1:0]  data;
    logic          soc;
    logic          en_n;
    logic          busy;
    logic [15:0]   cells_sent;

    utopia_tx_scheduler #(.IfWidth(W), .NumTx(N), .AddrWidth(AW), .CellBytes(53)) dut (
        .clk_in(clk_in), .reset(reset), .req(req), .cell_data_in(cell_data_in),
        .grant(grant), .rd_en(rd_en), .cell_done(cell_done), .phy_addr(phy_addr),
        .clav(clav), .data(data), .soc(soc), .en_n(en_n), .busy(busy), .cells_sent(cells_sent)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int n = 0;

    // model: engagement starts at cycle m_t when a request is seen while idle
    bit          m_eng, m_gr;
    int          m_t, m_cand, m_rr;
    logic [W-1:0] m_data;
    logic [15:0] m_cells;

    // stimulus controls
    logic [N-1:0] req_pat;
    int  clav_mode;
    bit  rand_req, seq_data, drop20, dropped;

    // observation counters
    int rd_cnt, soc_cnt, done_cnt, poll0_cnt;
    logic [N-1:0] prev_grant;
    logic [N-1:0] gq[$];
    int           gcyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        m_eng = 1'b0; m_gr = 1'b0; m_t = 0; m_cand = 0; m_rr = 0;
        m_data = '0; m_cells = 16'd0;
    endtask

    task automatic clear_obs();
        rd_cnt = 0; soc_cnt = 0; done_cnt = 0; poll0_cnt = 0;
        prev_grant = '0; gq.delete(); gcyc.delete();
    endtask

    task automatic check_outputs();
        int o;
        logic [N-1:0] oh;
        o  = n - m_t;
        oh = m_gr ? (N'(1) << m_cand) : '0;
        chk("busy",       32'(busy),       32'(m_eng));
        chk("phy_addr",   32'(phy_addr),   m_eng ? 32'(m_cand) : 32'h1F);
        chk("grant",      32'(grant),      32'(oh));
        chk("rd_en",      32'(rd_en),      32'(m_gr && o <= 55));
        chk("en_n",       32'(en_n),       32'(!(m_gr && o >= 4)));
        chk("soc",        32'(soc),        32'(m_gr && o == 4));
        chk("cell_done",  32'(cell_done),  32'(m_gr && o == 56));
        chk("data",       32'(data),       32'(m_data));
        chk("cells_sent", 32'(cells_sent), 32'(m_cells));
        chk("inv_onehot", 32'($countones(grant) <= 1), 32'd1);
        chk("inv_rd_en",  32'(!rd_en || $countones(grant) == 1), 32'd1);
        chk("inv_soc",    32'(!soc || !en_n), 32'd1);
        if (rd_en) rd_cnt++;
        if (soc) soc_cnt++;
        if (cell_done) done_cnt++;
        if (phy_addr == 5'd0) poll0_cnt++;
        if (grant != '0 && prev_grant == '0) begin
            gq.push_back(grant);
            gcyc.push_back(n);
        end
        prev_grant = grant;
    endtask

    task automatic drive_inputs();
        logic [N-1:0] r;
        r = rand_req ? N'($urandom) : req_pat;
        case (clav_mode)
            0:       clav = 1'b1;
            1:       clav = !(m_eng && m_cand == 0);
            default: clav = 1'($urandom_range(0, 1));
        endcase
        if (drop20 && m_gr && (n - m_t) >= 23) dropped = 1'b1;
        if (dropped) begin
            r    = '0;
            clav = 1'b0;
        end
        req = r;
        cell_data_in = (seq_data && m_gr) ? W'(n - m_t - 3) : W'($urandom);
    endtask

    task automatic model_update();
        int o;
        if (!m_eng) begin
            if (req != '0) begin
                m_eng = 1'b1;
                m_t   = n;
                for (int k = 0; k < N; k++) begin
                    if (req[(m_rr + k) % N]) begin
                        m_cand = (m_rr + k) % N;
                        break;
                    end
                end
            end
        end else begin
            o = n - m_t;
            if (o == 2) begin
                if (clav && req[m_cand]) m_gr = 1'b1;
                else begin
                    m_rr  = (m_cand + 1) % N;
                    m_eng = 1'b0;
                end
            end else if (m_gr && o >= 3 && o <= 55) begin
                m_data = cell_data_in;
                if (o == 55) m_cells = m_cells + 16'd1;
            end else if (m_gr && o == 56) begin
                m_eng = 1'b0;
                m_gr  = 1'b0;
                m_rr  = (m_cand + 1) % N;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        n++;
        check_outputs();
        drive_inputs();
        model_update();
    endtask

    // reset pulse inside the low half of the clock; model restarts from idle
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        clear_obs();
        drive_inputs();
        model_update();
    endtask

    initial begin
        bit reached;
        reset = 1'b1; req = '0; clav = 1'b0; cell_data_in = '0;
        req_pat = '0; clav_mode = 0; rand_req = 1'b0; seq_data = 1'b0;
        drop20 = 1'b0; dropped = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk_in);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_done",  32'(cell_done), 32'd0);
        chk("rst_phy",   32'(phy_addr), 32'h1F);
        chk("rst_data",  32'(data), 32'd0);
        chk("rst_soc",   32'(soc), 32'd0);
        chk("rst_en_n",  32'(en_n), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_cells", 32'(cells_sent), 32'd0);
        reset = 1'b0;

        // single cell from source 0 with bytes 0x00..0x34
        req_pat = 4'b0001; clav_mode = 0; seq_data = 1'b1;
        repeat (58) step();
        chk("t1_rd_pulses", 32'(rd_cnt), 32'd53);
        chk("t1_soc_count", 32'(soc_cnt), 32'd1);
        chk("t1_done_count", 32'(done_cnt), 32'd1);
        chk("t1_last_byte", 32'(data), 32'h34);
        chk("t1_cells", 32'(cells_sent), 32'd1);

        // all four requesting: strict rotation, 57-cycle spacing
        req_pat = 4'b1111; seq_data = 1'b0;
        apply_reset();
        repeat (285) step();
        chk("t2_cells", 32'(cells_sent), 32'd5);
        chk("t2_ngrants", 32'(gq.size()), 32'd5);
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            logic [N-1:0] want;
            want = N'(1) << (i % N);
            chk("t2_order", 32'(gq[i]), 32'(want));
            if (i > 0) chk("t2_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd57);
        end

        // PHY 0 never ready: it is polled and skipped, source 1 carries traffic
        req_pat = 4'b0011; clav_mode = 1;
        apply_reset();
        repeat (200) step();
        chk("t3_grants_seen", 32'(gq.size() >= 2), 32'd1);
        for (int i = 0; i < gq.size(); i++) chk("t3_grant", 32'(gq[i]), 32'b0010);
        chk("t3_polled0", 32'(poll0_cnt >= 4), 32'd1);

        // req/clav drop at word 20: the cell still completes
        req_pat = 4'b0001; clav_mode = 0; drop20 = 1'b1; dropped = 1'b0;
        apply_reset();
        repeat (120) step();
        chk("t4_rd_pulses", 32'(rd_cnt), 32'd53);
        chk("t4_done_count", 32'(done_cnt), 32'd1);
        chk("t4_cells", 32'(cells_sent), 32'd1);

        // reset at word 30, then a fresh cell
        drop20 = 1'b0; dropped = 1'b0;
        apply_reset();
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (m_gr && (n - m_t) == 33) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t5_reached_word30", 32'(reached), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t5_en_n", 32'(en_n), 32'd1);
        chk("t5_soc", 32'(soc), 32'd0);
        chk("t5_grant", 32'(grant), 32'd0);
        chk("t5_rd_en", 32'(rd_en), 32'd0);
        chk("t5_phy", 32'(phy_addr), 32'h1F);
        apply_reset();
        repeat (58) step();
        chk("t5_soc_count", 32'(soc_cnt), 32'd1);
        chk("t5_done_count", 32'(done_cnt), 32'd1);

        // counter wrap from 0xFFFF
        req_pat = 4'b0000;
        apply_reset();
        step();
        force dut.cells_sent_q = 16'hFFFF;
        m_cells = 16'hFFFF;
        step();
        release dut.cells_sent_q;
        step();
        req_pat = 4'b0001;
        repeat (58) step();
        chk("t6_wrap", 32'(cells_sent), 32'd0);

        // random requests and clav
        rand_req = 1'b1; clav_mode = 2;
        apply_reset();
        repeat (1500) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
